display_scheduler: RTL

- Owns the 4-digit display datapath: produces the 16-bit BCD word fed to display7seg_4dig.bcd_in.
- Rotates between occupancy count and room capacity on a dwell timer.
- Converts binary to BCD with a sequential shift-add converter.
- Lets an alert requester preempt the display for a fixed time through a req/ack handshake.

---
 rtl/disp_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 52 +++++
 rtl/display_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared encodings and constants for the 4-digit display scheduler.
// Display source codes, FSM states, BCD markers and the leading-zero blanking helper.
package disp_pkg;

    localparam logic [1:0] SRC_OCC   = 2'd0;
    localparam logic [1:0] SRC_CAP   = 2'd1;
    localparam logic [1:0] SRC_ALERT = 2'd2;

    typedef enum logic [1:0] {
        ST_SEL   = 2'd0,
        ST_CONV  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ALERT = 2'd3
    } state_t;

    localparam logic [3:0]  BCD_BLANK = 4'hF;
    localparam logic [15:0] BCD_OVF   = 16'hFFFF;
    localparam int          MAX_DEC   = 9999;

    // Blank leading zero digits; the units digit always stays visible.
    function automatic logic [15:0] lz_blank(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (d[15:12] == 4'd0) begin
            r[15:12] = BCD_BLANK;
            if (d[11:8] == 4'd0) begin
                r[11:8] = BCD_BLANK;
                if (d[7:4] == 4'd0) begin
                    r[7:4] = BCD_BLANK;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// Only four digits are kept; values above 9999 are flagged upstream and never shown.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] shift;
    logic [15:0]      acc;
    logic [CNT_W-1:0] cnt;

    function automatic logic [15:0] dabble(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // done marks the cycle whose edge performs the final shift
    assign done = (cnt == CNT_W'(1));
    assign bcd  = acc;

    always_ff @(posedge clk) begin
        if (!reset || abort) begin
            cnt <= '0;
        end else if (start) begin
            shift <= bin_in;
            acc   <= '0;
            cnt   <= CNT_W'(BIN_W);
        end else if (cnt != '0) begin
            acc   <= (dabble(acc) << 1) | {15'd0, shift[BIN_W-1]};
            shift <= shift << 1;
            cnt   <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Display datapath: rotates occupancy/capacity through a BCD converter, with alert preemption.
// Optional macro DISPLAY_SCHEDULER_LZ_BLANK_EN blanks leading zeros of converted values.
module display_scheduler
    import disp_pkg::*;
#(
    parameter int BIN_W        = 14,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int ALERT_CYCLES = 300_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] occ_count,
    input  logic [BIN_W-1:0] capacity,
    input  logic             alert_req,
    input  logic [15:0]      alert_code,
    output logic             alert_ack,
    output logic [15:0]      bcd_out,
    output logic [1:0]       src_sel
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int AL_W = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;

    state_t           state;
    logic             slot;
    logic [1:0]       conv_src;
    logic             ovf;
    logic [DW_W-1:0]  dwell;
    logic [AL_W-1:0]  alert_tmr;

    logic             take;
    logic             dwell_wrap;
    logic             start;
    logic [BIN_W-1:0] bin_sel;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    function automatic logic [15:0] fmt_digits(input logic [15:0] d);
`ifdef DISPLAY_SCHEDULER_LZ_BLANK_EN
        return lz_blank(d);
`else
        return d;
`endif
    endfunction

    // An alert is accepted in any state but ALERT and aborts the running conversion
    assign take       = alert_req && (state != ST_ALERT);
    assign dwell_wrap = (dwell == DW_W'(DWELL_CYCLES - 1));
    assign start      = (state == ST_SEL) && !take;
    assign bin_sel    = slot ? capacity : occ_count;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_conv (
        .clk    (clk),
        .reset  (reset),
        .abort  (take),
        .start  (start),
        .bin_in (bin_sel),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_SEL;
            slot      <= 1'b0;
            conv_src  <= SRC_OCC;
            ovf       <= 1'b0;
            dwell     <= '0;
            alert_tmr <= '0;
            alert_ack <= 1'b0;
            bcd_out   <= 16'h0000;
            src_sel   <= SRC_OCC;
        end else begin
            alert_ack <= 1'b0;
            if (take) begin
                // Alert wins over a coincident dwell wrap: the toggle is dropped
                state     <= ST_ALERT;
                alert_tmr <= '0;
                alert_ack <= 1'b1;
                bcd_out   <= alert_code;
                src_sel   <= SRC_ALERT;
            end else begin
                if (state != ST_ALERT) begin
                    if (dwell_wrap) begin
                        dwell <= '0;
                        slot  <= ~slot;
                    end else begin
                        dwell <= dwell + DW_W'(1);
                    end
                end
                case (state)
                    ST_SEL: begin
                        conv_src <= slot ? SRC_CAP : SRC_OCC;
                        ovf      <= (32'(bin_sel) > 32'(MAX_DEC));
                        state    <= ST_CONV;
                    end
                    ST_CONV: begin
                        if (conv_done) begin
                            state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        bcd_out <= ovf ? BCD_OVF : fmt_digits(conv_bcd);
                        src_sel <= conv_src;
                        state   <= ST_SEL;
                    end
                    ST_ALERT: begin
                        // bcd_out keeps the alert code until the next LOAD
                        if (alert_tmr == AL_W'(ALERT_CYCLES - 1)) begin
                            state     <= ST_SEL;
                            slot      <= 1'b0;
                            dwell     <= '0;
                            alert_tmr <= '0;
                        end else begin
                            alert_tmr <= alert_tmr + AL_W'(1);
                        end
                    end
                    default: state <= ST_SEL;
                endcase
            end
        end
    end

endmodule
